// File: rtl/dct_xpose_ctrl.sv
// ============================================================================
// Module   : dct_xpose_ctrl
// Purpose  : Write/read sequencer for an 8x8 transpose RAM between DCT passes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_xpose_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_col,
    output logic       ram_we,
    output logic [2:0] ram_addr,
    output logic       busy,
    output logic       block_done
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        LAST  = 2'd2
    } state_t;

    localparam logic [2:0] C_LAST_IDX = 3'd7;

    state_t     state,         state_nxt;
    logic [2:0] wr_cnt,        wr_cnt_nxt;
    logic [2:0] rd_cnt,        rd_cnt_nxt;
    logic [2:0] out_col_nxt;
    logic       out_valid_nxt;
    logic       block_done_nxt;
    logic       stall;

    assign stall = out_valid && !out_ready;

    always_comb begin
        state_nxt      = state;
        wr_cnt_nxt     = wr_cnt;
        rd_cnt_nxt     = rd_cnt;
        out_col_nxt    = out_col;
        out_valid_nxt  = out_valid;
        block_done_nxt = 1'b0;
        in_ready       = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = 3'd0;

        if (!rst) begin
            case (state)
                FILL: begin
                    in_ready = 1'b1;
                    ram_we   = in_valid;
                    ram_addr = wr_cnt;
                    if (in_valid) begin
                        if (wr_cnt == C_LAST_IDX) begin
                            wr_cnt_nxt = 3'd0;
                            rd_cnt_nxt = 3'd0;
                            state_nxt  = DRAIN;
                        end else begin
                            wr_cnt_nxt = wr_cnt + 3'd1;
                        end
                    end
                end

                DRAIN: begin
                    // A stalled column is re-read so the RAM's registered outputs hold still.
                    ram_addr = stall ? out_col : rd_cnt;
                    if (!stall) begin
                        out_valid_nxt = 1'b1;
                        out_col_nxt   = rd_cnt;
                        rd_cnt_nxt    = rd_cnt + 3'd1;
                        if (rd_cnt == C_LAST_IDX) begin
                            state_nxt = LAST;
                        end
                    end
                end

                LAST: begin
                    ram_addr = C_LAST_IDX;
                    if (out_valid && out_ready) begin
                        out_valid_nxt  = 1'b0;
                        block_done_nxt = 1'b1;
                        state_nxt      = FILL;
                    end
                end

                default: begin
                    state_nxt = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            wr_cnt     <= 3'd0;
            rd_cnt     <= 3'd0;
            out_col    <= 3'd0;
            out_valid  <= 1'b0;
            block_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_cnt     <= wr_cnt_nxt;
            rd_cnt     <= rd_cnt_nxt;
            out_col    <= out_col_nxt;
            out_valid  <= out_valid_nxt;
            block_done <= block_done_nxt;
        end
    end

    assign busy = (state != FILL) || (wr_cnt != 3'd0);

endmodule

`default_nettype wire

// File: tb/tb_dct_xpose_ctrl.sv
// ============================================================================
// Module   : tb_dct_xpose_ctrl
// Purpose  : Bench for dct_xpose_ctrl with an 8x8 RAM and block-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dct_xpose_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_col;
    logic       ram_we;
    logic [2:0] ram_addr;
    logic       busy;
    logic       block_done;

    always #5 clk = ~clk;

    dct_xpose_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_col    (out_col),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .busy       (busy),
        .block_done (block_done)
    );

    // Transpose RAM: row writes, registered column reads on every non-write edge.
    logic [7:0] row_in [8];
    logic [7:0] mem    [8][8];
    logic [7:0] dout   [8];

    always @(posedge clk) begin
        if (ram_we) begin
            for (int c = 0; c < 8; c++) mem[ram_addr][c] <= row_in[c];
        end else begin
            for (int r = 0; r < 8; r++) dout[r] <= mem[r][ram_addr];
        end
    end

    // Block-level reference: rows accepted, columns consumed, one idle drain cycle.
    int         acc;
    int         ncons;
    bit         dwait;
    bit         done_exp;
    logic [7:0] blk [8][8];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rs, input bit iv, input bit ordy, input bit pattern);
        logic [63:0] got_col;
        logic [63:0] exp_col;
        logic [2:0]  exp_addr;
        rst       = rs;
        in_valid  = iv;
        out_ready = ordy;
        for (int c = 0; c < 8; c++)
            row_in[c] = pattern ? 8'((8 * (acc % 8)) + c) : 8'($urandom);
        @(negedge clk);
        if (rs) begin
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_ram_we",   {63'd0, ram_we},   64'd0);
            chk("rst_ram_addr", {61'd0, ram_addr}, 64'd0);
        end else begin
            chk("in_ready",   {63'd0, in_ready},   {63'd0, acc < 8});
            chk("ram_we",     {63'd0, ram_we},     {63'd0, (acc < 8) && iv});
            chk("busy",       {63'd0, busy},       {63'd0, acc != 0});
            chk("block_done", {63'd0, block_done}, {63'd0, done_exp});
            chk("out_valid",  {63'd0, out_valid},  {63'd0, (acc == 8) && !dwait});
            if (acc < 8)       exp_addr = 3'(acc);
            else if (dwait)    exp_addr = 3'd0;
            else if (!ordy)    exp_addr = 3'(ncons);
            else               exp_addr = (ncons < 7) ? 3'(ncons + 1) : 3'd7;
            chk("ram_addr", {61'd0, ram_addr}, {61'd0, exp_addr});
            if ((acc == 8) && !dwait) begin
                chk("out_col", {61'd0, out_col}, 64'(ncons));
                for (int r = 0; r < 8; r++) begin
                    got_col[r*8 +: 8] = dout[r];
                    exp_col[r*8 +: 8] = blk[r][ncons];
                end
                chk("col_data", got_col, exp_col);
            end
        end
        done_exp = 1'b0;
        if (rs) begin
            acc = 0; ncons = 0; dwait = 1'b0;
        end else if (acc < 8) begin
            if (iv) begin
                for (int c = 0; c < 8; c++) blk[acc][c] = row_in[c];
                acc++;
                if (acc == 8) dwait = 1'b1;
            end
        end else if (dwait) begin
            dwait = 1'b0;
        end else if (ordy) begin
            ncons++;
            if (ncons == 8) begin
                acc = 0; ncons = 0; done_exp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit     hit;
        int     gap_pat [5] = '{1, 0, 1, 1, 0};
        acc = 0; ncons = 0; dwait = 1'b0; done_exp = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 8; c++) row_in[c] = 8'd0;
        @(posedge clk); #1;
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);

        // Back-to-back blocks with in_valid held high through the drain.
        for (int i = 0; i < 40; i++) step(0, 1, 1, 1);

        // Input gaps during fill.
        for (int i = 0; i < 45; i++) step(0, gap_pat[i % 5] != 0, 1, 1);

        // Abort mid-drain at column 2, then a clean block.
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if ((acc == 8) && !dwait && (ncons == 2)) hit = 1'b1;
            else step(0, 1, 1, 0);
        end
        if (!hit) chk("bound_col2", 64'd0, 64'd1);
        step(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 1);

        // Long stalls on the output side.
        for (int i = 0; i < 60; i++) step(0, 1, (i % 10) < 4, 0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 120) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
